// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access path.
// Latency: n/a; backpressure: n/a.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/load_extend.sv
// Byte/half lane select with sign or zero extension of a loaded word.
// Latency: combinational; backpressure: none.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{addr_lo, 3'b000} +: 8];
    lane_h = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'h0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'h0, lane_h};
      F3_W:    data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store to word-memory adapter; loads and SW are zero-latency, SB/SH do a 2-cycle RMW.
// Latency: 0 cycles (loads/SW), 1 extra cycle for SB/SH; backpressure: stall held high in the RMW read cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              access_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] held_addr_q, held_addr_d;
  logic [DATA_W-1:0] held_word_q, held_word_d;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] merged;
  logic [ADDR_W-1:0] word_addr;
  logic              aligned, legal_load, legal_store, load_ok, store_ok, bad_req;

  load_extend u_load_extend (
    .word    (mem_read_data),
    .addr_lo (addr[1:0]),
    .funct3  (funct3),
    .data    (load_word)
  );

  always_comb begin
    word_addr   = {addr[ADDR_W-1:2], 2'b00};
    aligned     = (funct3[1:0] == 2'b00)
                | ((funct3[1:0] == 2'b01) && !addr[0])
                | ((funct3[1:0] == 2'b10) && (addr[1:0] == 2'b00));
    legal_load  = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    legal_store = funct3 inside {F3_B, F3_H, F3_W};
    load_ok     = req_read && !req_write && legal_load && aligned;
    store_ok    = req_write && !req_read && legal_store && aligned;
    bad_req     = (req_read || req_write) && !load_ok && !store_ok;

    // Only the addressed lane(s) of the current memory word are replaced.
    merged = mem_read_data;
    if (funct3[1:0] == 2'b00)
      merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    else
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
  end

  always_comb begin
    state_d        = state_q;
    held_addr_d    = held_addr_q;
    held_word_d    = held_word_q;
    rdata          = '0;
    stall          = 1'b0;
    access_fault   = 1'b0;
    mem_addr       = word_addr;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    case (state_q)
      IDLE: begin
        access_fault = bad_req;
        if (load_ok)
          rdata = load_word;
        if (store_ok) begin
          if (funct3 == F3_W) begin
            mem_write_en   = 1'b1;
            mem_write_data = wdata;
          end else begin
            stall       = 1'b1;
            held_addr_d = word_addr;
            held_word_d = merged;
            state_d     = RMW_WRITE;
          end
        end
      end
      RMW_WRITE: begin
        // Core re-presents the held store here, so request inputs are ignored.
        mem_addr       = held_addr_q;
        mem_write_en   = 1'b1;
        mem_write_data = held_word_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      held_addr_q <= '0;
      held_word_q <= '0;
    end else begin
      state_q     <= state_d;
      held_addr_q <= held_addr_d;
      held_word_q <= held_word_d;
    end
  end

endmodule
